// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and key-to-matrix-position map for the keypad emulator.
package keypad_pkg;
  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, DONE} emu_state_t;
  // Indexed by key code, each entry is {row, col}
  localparam logic [3:0] KEY_POS [16] = '{
    4'b11_01, 4'b00_00, 4'b00_01, 4'b00_10,
    4'b01_00, 4'b01_01, 4'b01_10, 4'b10_00,
    4'b10_01, 4'b10_10, 4'b00_11, 4'b01_11,
    4'b10_11, 4'b11_11, 4'b11_00, 4'b11_10
  };
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    return KEY_POS[key];
  endfunction
endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11) supplying contact-bounce samples.
module bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic load,
  output logic out
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr <= SEED;
    else if (load) lfsr <= SEED;
    else if (step) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign out = lfsr[0];
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: keypad-side responder driving column lines from scanner rows, with optional contact bounce.
module keypad_emulator import keypad_pkg::*; #(
  parameter int          BOUNCE_CYCLES = 64,
  parameter int          BOUNCE_STEP   = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                press_valid,
  output logic                press_ready,
  input  logic [3:0]          press_key,
  input  logic [15:0]         hold_cycles,
  input  logic                bounce_en,
  input  logic [KEY_ROWS-1:0] r,
  output logic [KEY_COLS-1:0] c,
  output logic                busy,
  output logic                done,
  output logic                contact
);
  localparam int CW = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BOUNCE_CYCLES - 1);
  emu_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [15:0] hold_cnt;
  logic [3:0] key_lat;
  logic [1:0] kr, kc;
  logic bounce_lat, run, accept, in_bounce, win_end, hold_end, step, lfsr_bit;
  assign cnt_inc     = cnt + CW'(1);
  assign press_ready = run && state == IDLE;
  assign accept      = press_valid && press_ready;
  assign in_bounce   = state == BOUNCE_IN || state == BOUNCE_OUT;
  assign win_end     = in_bounce && cnt == LAST;
  assign hold_end    = state == HOLD && hold_cnt == 16'd1;
  // A sample is taken on entry to each window and whenever the next cycle lands on a step boundary
  assign step = (accept && bounce_en) || (hold_end && bounce_lat) ||
                (in_bounce && !win_end && int'(cnt_inc) % BOUNCE_STEP == 0);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign {kr, kc} = key_pos(key_lat);
  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (step),
    .load (1'b0),
    .out  (lfsr_bit)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = accept ? (bounce_en ? BOUNCE_IN : HOLD) : IDLE;
      BOUNCE_IN:  state_nxt = win_end ? HOLD : BOUNCE_IN;
      HOLD:       state_nxt = hold_end ? (bounce_lat ? BOUNCE_OUT : DONE) : HOLD;
      BOUNCE_OUT: state_nxt = win_end ? DONE : BOUNCE_OUT;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run        <= 1'b0;
      key_lat    <= '0;
      bounce_lat <= 1'b0;
      hold_cnt   <= '0;
      cnt        <= '0;
      contact    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        key_lat    <= press_key;
        bounce_lat <= bounce_en;
      end
      hold_cnt <= accept ? (hold_cycles == 16'd0 ? 16'd1 : hold_cycles) :
                  (state == HOLD && !hold_end) ? hold_cnt - 16'd1 : hold_cnt;
      cnt      <= (in_bounce && !win_end) ? cnt_inc : '0;
      contact  <= step ? lfsr_bit : (state_nxt == HOLD) || (in_bounce && !win_end && contact);
    end
  always_comb begin
    c     = '0;
    c[kc] = contact & r[kr];
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: scoreboard bench; each press pushes its per-cycle expected trace, popped every cycle.
module tb_keypad_emulator;
  localparam int BC = 64;
  localparam int BS = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, reset = 0, press_valid = 0, bounce_en = 0;
  logic [3:0] press_key = 0, r = 0;
  logic [15:0] hold_cycles = 0;
  logic press_ready, busy, done, contact;
  logic [3:0] c;
  int errors = 0, checks = 0;
  logic [15:0] m_lfsr = SEED;
  logic [7:0] got, want;
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};
  typedef struct {logic ready; logic busy; logic done; logic contact; logic [3:0] key;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  keypad_emulator dut (
    .clk(clk), .reset(reset), .press_valid(press_valid), .press_ready(press_ready),
    .press_key(press_key), .hold_cycles(hold_cycles), .bounce_en(bounce_en),
    .r(r), .c(c), .busy(busy), .done(done), .contact(contact)
  );

  function automatic logic [3:0] exp_c(input logic ct, input logic [3:0] key, input logic [3:0] rv);
    logic [3:0] res = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (kmap[i][j] == key && ct && rv[i]) res[j] = 1'b1;
    return res;
  endfunction

  function automatic exp_t mk(input logic rd, input logic bz, input logic dn, input logic ct, input logic [3:0] k);
    exp_t x;
    x.ready = rd; x.busy = bz; x.done = dn; x.contact = ct; x.key = k;
    return x;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic push_win(input logic [3:0] key);
    logic cur = 1'b0;
    for (int k = 0; k < BC; k++) begin
      if (k % BS == 0) begin
        cur = m_lfsr[0];
        m_lfsr = lfsr_next(m_lfsr);
      end
      q.push_back(mk(1'b0, 1'b1, 1'b0, cur, key));
    end
  endtask

  task automatic push_seq(input logic [3:0] key, input int hold, input logic ben);
    int h = (hold == 0) ? 1 : hold;
    if (ben) push_win(key);
    repeat (h) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, key));
    if (ben) push_win(key);
    q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, key));
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, key));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!press_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!press_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: press_ready=%b required 1", name, press_ready);
    end
  endtask

  task automatic start(input logic [3:0] key, input logic [15:0] hold, input logic ben);
    press_key = key; hold_cycles = hold; bounce_en = ben; press_valid = 1'b1;
    push_seq(key, hold, ben);
  endtask

  task automatic test_reset;
    reset = 1'b0; r = 4'hF;
    repeat (2) @(negedge clk);
    checks++;
    got = {press_ready, busy, done, contact, c};
    if (got !== 8'h00) begin errors++; $display("FAIL reset_state: got %b want %b", got, 8'h00); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (press_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", press_ready); end
  endtask

  task automatic test_clean;
    wait_ready("clean");
    r = 4'b0010;
    start(4'h5, 16'd10, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      press_valid = 1'b0; press_key = 4'h1; hold_cycles = 16'd99; bounce_en = 1'b1;
      e = q.pop_front();
      got = {press_ready, busy, done, contact, c};
      want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
      checks++;
      if (got !== want) begin errors++; $display("FAIL clean: got %b want %b", got, want); end
    end
  endtask

  task automatic test_map;
    logic [3:0] keys [4] = '{4'h1, 4'hD, 4'hE, 4'h0};
    for (int k = 0; k < 4; k++) begin
      wait_ready("map");
      r = 4'b0001;
      start(keys[k], 16'd4, 1'b0);
      while (q.size() > 0) begin
        @(negedge clk);
        press_valid = 1'b0;
        e = q.pop_front();
        got = {press_ready, busy, done, contact, c};
        want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
        checks++;
        if (got !== want) begin errors++; $display("FAIL map_key%h r=%b: got %b want %b", e.key, r, got, want); end
        r = {r[2:0], r[3]};
      end
    end
  endtask

  task automatic test_bounce;
    int span = 0;
    wait_ready("bounce");
    r = 4'b0001;
    start(4'hA, 16'd20, 1'b1);
    while (q.size() > 0) begin
      @(negedge clk);
      press_valid = 1'b0;
      e = q.pop_front();
      if (busy === 1'b1) span++;
      got = {press_ready, busy, done, contact, c};
      want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
      checks++;
      if (got !== want) begin errors++; $display("FAIL bounce: got %b want %b", got, want); end
    end
    checks++;
    if (span != 2 * BC + 20 + 1) begin errors++; $display("FAIL bounce_span: got %0d want %0d", span, 2 * BC + 21); end
  endtask

  task automatic test_hold_zero;
    wait_ready("hold0");
    r = 4'b0010;
    start(4'h5, 16'd0, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      press_valid = 1'b0;
      e = q.pop_front();
      got = {press_ready, busy, done, contact, c};
      want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
      checks++;
      if (got !== want) begin errors++; $display("FAIL hold_zero: got %b want %b", got, want); end
    end
  endtask

  task automatic test_back_to_back;
    logic second = 1'b0;
    wait_ready("b2b");
    r = 4'hF;
    start(4'h3, 16'd3, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      got = {press_ready, busy, done, contact, c};
      want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
      checks++;
      if (got !== want) begin errors++; $display("FAIL back_to_back: got %b want %b", got, want); end
      if (e.ready && !second) begin
        second = 1'b1;
        start(4'hC, 16'd3, 1'b0);
      end
    end
    press_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    wait_ready("reset_mid");
    r = 4'b0010;
    start(4'h5, 16'd10, 1'b0);
    repeat (4) begin
      @(negedge clk);
      press_valid = 1'b0;
      e = q.pop_front();
      got = {press_ready, busy, done, contact, c};
      want = {e.ready, e.busy, e.done, e.contact, exp_c(e.contact, e.key, r)};
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset_mid_pre: got %b want %b", got, want); end
    end
    q.delete();
    m_lfsr = SEED;
    reset = 1'b0;
    #1;
    got = {press_ready, busy, done, contact, c};
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL reset_mid: got %b want %b", got, 8'h00); end
    @(negedge clk);
    got = {press_ready, busy, done, contact, c};
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL reset_mid_hold: got %b want %b", got, 8'h00); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (press_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b want 1", press_ready); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_map();
    test_bounce();
    test_hold_zero();
    test_back_to_back();
    test_reset_mid();
    test_bounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
